// File: rtl/mem_stage.sv
// LEGv8 memory stage: EX/MEM register, multi-cycle data-memory handshake, MEM/WB register, ALU forwarding.
// Optional access timeout with a sticky error flag is enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [63:0] ex_result,
  input  logic [63:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic [63:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [63:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        fwd_en,
  output logic [4:0]  fwd_rd,
  output logic [63:0] fwd_data,
  output logic        mem_error
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;

  logic        exm_valid_r;
  logic [63:0] exm_result_r;
  logic [63:0] exm_store_data_r;
  logic [4:0]  exm_rd_r;
  logic        exm_mem_read_r;
  logic        exm_mem_write_r;
  logic        exm_reg_write_r;
  logic        exm_fwd_r;

  logic        wb_valid_r;
  logic [63:0] wb_data_r;
  logic [4:0]  wb_rd_r;
  logic        wb_reg_write_r;

  logic        in_access_s;
  logic        capture_mem_s;
  logic        abort_s;
  logic        stall_s;
  logic        mem_error_s;

  generate
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("mem_stage: TIMEOUT must lie within 2..255");
    end
  endgenerate

  assign in_access_s   = (state_r == ACCESS);
  assign capture_mem_s = ex_valid & (ex_mem_read | ex_mem_write);

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] tmo_cnt_r;
  logic       mem_error_r;

  // An ack arriving in the final cycle takes priority over the abort.
  assign abort_s     = in_access_s & ~dmem_ack & (tmo_cnt_r == TIMEOUT_LAST);
  assign mem_error_s = mem_error_r;

  // Wait counter restarts whenever the stage advances; error flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt_r   <= 8'd0;
      mem_error_r <= 1'b0;
    end else begin
      if (stall_s) begin
        tmo_cnt_r <= tmo_cnt_r + 8'd1;
      end else begin
        tmo_cnt_r <= 8'd0;
      end
      if (abort_s) begin
        mem_error_r <= 1'b1;
      end
    end
  end
`else
  assign abort_s     = 1'b0;
  assign mem_error_s = 1'b0;
`endif

  assign stall_s = in_access_s & ~dmem_ack & ~abort_s;

  // Next-state: hold while stalled, otherwise follow the op being captured.
  always_comb begin
    state_next_s = state_r;
    if (stall_s) begin
      state_next_s = state_r;
    end else if (capture_mem_s) begin
      state_next_s = ACCESS;
    end else begin
      state_next_s = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // EX/MEM register; a simultaneous read+write is captured as a store.
  always_ff @(posedge clk) begin
    if (!reset) begin
      exm_valid_r      <= 1'b0;
      exm_result_r     <= 64'd0;
      exm_store_data_r <= 64'd0;
      exm_rd_r         <= 5'd0;
      exm_mem_read_r   <= 1'b0;
      exm_mem_write_r  <= 1'b0;
      exm_reg_write_r  <= 1'b0;
      exm_fwd_r        <= 1'b0;
    end else if (!stall_s) begin
      exm_valid_r      <= ex_valid;
      exm_result_r     <= ex_result;
      exm_store_data_r <= ex_store_data;
      exm_rd_r         <= ex_rd;
      exm_mem_read_r   <= ex_valid & ex_mem_read & ~ex_mem_write;
      exm_mem_write_r  <= ex_valid & ex_mem_write;
      exm_reg_write_r  <= ex_valid & ex_reg_write;
      exm_fwd_r        <= ex_valid & ex_reg_write & ~ex_mem_read & ~ex_mem_write
                          & (ex_rd != 5'd31);
    end
  end

  // MEM/WB register; a stall or an aborted access inserts a bubble and keeps data/rd.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_valid_r     <= 1'b0;
      wb_data_r      <= 64'd0;
      wb_rd_r        <= 5'd0;
      wb_reg_write_r <= 1'b0;
    end else if (stall_s || abort_s) begin
      wb_valid_r     <= 1'b0;
      wb_reg_write_r <= 1'b0;
    end else begin
      wb_valid_r     <= exm_valid_r;
      wb_data_r      <= exm_mem_read_r ? dmem_rdata : exm_result_r;
      wb_rd_r        <= exm_rd_r;
      wb_reg_write_r <= exm_valid_r & exm_reg_write_r & ~exm_mem_write_r
                        & (exm_rd_r != 5'd31);
    end
  end

  assign stall        = stall_s;
  assign dmem_req     = in_access_s;
  assign dmem_we      = in_access_s & exm_mem_write_r;
  assign dmem_addr    = exm_result_r;
  assign dmem_wdata   = exm_store_data_r;
  assign wb_valid     = wb_valid_r;
  assign wb_data      = wb_data_r;
  assign wb_rd        = wb_rd_r;
  assign wb_reg_write = wb_reg_write_r;
  assign fwd_en       = exm_fwd_r;
  assign fwd_rd       = exm_rd_r;
  assign fwd_data     = exm_result_r;
  assign mem_error    = mem_error_s;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level model compared every cycle, plus directed literal checks.
// Timeout scenarios run only when MEM_STAGE_TIMEOUT_EN is defined.
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [63:0] ex_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        stall, dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid, wb_reg_write, fwd_en, mem_error;
  logic [63:0] wb_data, fwd_data;
  logic [4:0]  wb_rd, fwd_rd;

  int errors = 0;
  int checks = 0;
  bit checks_on = 1'b0;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .fwd_en(fwd_en), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the instruction sitting in the memory stage and what it retires as.
  typedef struct packed {
    logic        valid;
    logic        load;
    logic        store;
    logic        rw;
    logic [4:0]  rd;
    logic [63:0] result;
    logic [63:0] sdata;
  } op_t;

  op_t         m_op = '0;
  logic        m_busy = 1'b0;
  int          m_wait = 0;
  logic        mw_valid = 1'b0, mw_rw = 1'b0, m_err = 1'b0;
  logic [63:0] mw_data = 64'd0;
  logic [4:0]  mw_rd = 5'd0;

  function automatic logic m_abort();
`ifdef MEM_STAGE_TIMEOUT_EN
    return m_busy & ~dmem_ack & (m_wait == TO - 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_stall();
    return m_busy & ~dmem_ack & ~m_abort();
  endfunction

  function automatic logic exp_fwd();
    return m_op.valid & m_op.rw & ~m_op.load & ~m_op.store & (m_op.rd != 5'd31);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_op <= '0; m_busy <= 1'b0; m_wait <= 0; m_err <= 1'b0;
      mw_valid <= 1'b0; mw_rw <= 1'b0; mw_data <= 64'd0; mw_rd <= 5'd0;
    end else if (exp_stall()) begin
      mw_valid <= 1'b0; mw_rw <= 1'b0; m_wait <= m_wait + 1;
    end else begin
      if (m_abort()) begin
        mw_valid <= 1'b0; mw_rw <= 1'b0; m_err <= 1'b1;
      end else begin
        mw_valid <= m_op.valid;
        mw_rw    <= m_op.valid & m_op.rw & ~m_op.store & (m_op.rd != 5'd31);
        mw_data  <= m_op.load ? dmem_rdata : m_op.result;
        mw_rd    <= m_op.rd;
      end
      m_op.valid  <= ex_valid;
      m_op.load   <= ex_valid & ex_mem_read & ~ex_mem_write;
      m_op.store  <= ex_valid & ex_mem_write;
      m_op.rw     <= ex_valid & ex_reg_write;
      m_op.rd     <= ex_rd;
      m_op.result <= ex_result;
      m_op.sdata  <= ex_store_data;
      m_busy      <= ex_valid & (ex_mem_read | ex_mem_write);
      m_wait      <= 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always begin
    @(negedge clk);
    #1;
    if (checks_on) begin
      chk("m.stall", stall, exp_stall());
      chk("m.dmem_req", dmem_req, m_busy);
      if (m_busy) begin
        chk("m.dmem_we", dmem_we, m_op.store);
        chk("m.dmem_addr", dmem_addr, m_op.result);
        if (m_op.store) chk("m.dmem_wdata", dmem_wdata, m_op.sdata);
      end
      chk("m.wb_valid", wb_valid, mw_valid);
      chk("m.wb_reg_write", wb_reg_write, mw_rw);
      chk("m.wb_data", wb_data, mw_data);
      chk("m.wb_rd", wb_rd, mw_rd);
      chk("m.fwd_en", fwd_en, exp_fwd());
      if (exp_fwd()) begin
        chk("m.fwd_rd", fwd_rd, m_op.rd);
        chk("m.fwd_data", fwd_data, m_op.result);
      end
      chk("m.mem_error", mem_error, m_err);
    end
  end

  task automatic set_op(input logic v, input logic mr, input logic mw, input logic rw,
                        input logic [4:0] rd, input logic [63:0] res, input logic [63:0] sd);
    ex_valid = v; ex_mem_read = mr; ex_mem_write = mw; ex_reg_write = rw;
    ex_rd = rd; ex_result = res; ex_store_data = sd;
  endtask

  task automatic idle_op();
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
  endtask

  initial begin
    reset = 1'b0; dmem_ack = 1'b0; dmem_rdata = 64'd0;
    set_op(1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 64'h99, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    set_op(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 64'h5, 64'd0);
    #1;
    chk("rst.stall", stall, 1'b0);        chk("rst.dmem_req", dmem_req, 1'b0);
    chk("rst.dmem_we", dmem_we, 1'b0);    chk("rst.dmem_addr", dmem_addr, 64'd0);
    chk("rst.dmem_wdata", dmem_wdata, 64'd0);
    chk("rst.wb_valid", wb_valid, 1'b0);  chk("rst.wb_data", wb_data, 64'd0);
    chk("rst.wb_rd", wb_rd, 5'd0);        chk("rst.wb_reg_write", wb_reg_write, 1'b0);
    chk("rst.fwd_en", fwd_en, 1'b0);      chk("rst.fwd_rd", fwd_rd, 5'd0);
    chk("rst.fwd_data", fwd_data, 64'd0); chk("rst.mem_error", mem_error, 1'b0);
    checks_on = 1'b1;

    // ALU op: forward next cycle, writeback the cycle after
    @(negedge clk); idle_op(); #1;
    chk("add.fwd_en", fwd_en, 1'b1); chk("add.fwd_rd", fwd_rd, 5'd3); chk("add.fwd_data", fwd_data, 64'h5);
    @(negedge clk); #1;
    chk("add.wb_valid", wb_valid, 1'b1); chk("add.wb_data", wb_data, 64'h5);
    chk("add.wb_rd", wb_rd, 5'd3);       chk("add.wb_reg_write", wb_reg_write, 1'b1);

    // Load acked on the third request cycle
    @(negedge clk); set_op(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 64'h100, 64'd0);
    @(negedge clk); idle_op(); #1;
    chk("ld.req1", dmem_req, 1'b1); chk("ld.we", dmem_we, 1'b0); chk("ld.addr1", dmem_addr, 64'h100);
    chk("ld.stall1", stall, 1'b1);  chk("ld.fwd_en", fwd_en, 1'b0);
    @(negedge clk); #1;
    chk("ld.stall2", stall, 1'b1); chk("ld.addr2", dmem_addr, 64'h100);
    @(negedge clk); dmem_ack = 1'b1; dmem_rdata = 64'hDEADBEEF; #1;
    chk("ld.stall3", stall, 1'b0); chk("ld.req3", dmem_req, 1'b1); chk("ld.addr3", dmem_addr, 64'h100);
    @(negedge clk); dmem_ack = 1'b0; dmem_rdata = 64'd0; #1;
    chk("ld.wb_valid", wb_valid, 1'b1); chk("ld.wb_data", wb_data, 64'hDEADBEEF);
    chk("ld.wb_rd", wb_rd, 5'd7);       chk("ld.wb_reg_write", wb_reg_write, 1'b1);
    chk("ld.req_off", dmem_req, 1'b0);

    // Store with zero-wait ack
    @(negedge clk); set_op(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 64'h40, 64'h1234);
    @(negedge clk); idle_op(); dmem_ack = 1'b1; #1;
    chk("st.req", dmem_req, 1'b1); chk("st.we", dmem_we, 1'b1); chk("st.addr", dmem_addr, 64'h40);
    chk("st.wdata", dmem_wdata, 64'h1234); chk("st.stall", stall, 1'b0);
    @(negedge clk); dmem_ack = 1'b0; #1;
    chk("st.wb_valid", wb_valid, 1'b1); chk("st.wb_reg_write", wb_reg_write, 1'b0);
    chk("st.req_off", dmem_req, 1'b0);

    // Destination X31
    @(negedge clk); set_op(1'b1, 1'b0, 1'b0, 1'b1, 5'd31, 64'h77, 64'd0);
    @(negedge clk); idle_op(); #1;
    chk("x31.fwd_en", fwd_en, 1'b0);
    @(negedge clk); #1;
    chk("x31.wb_valid", wb_valid, 1'b1); chk("x31.wb_reg_write", wb_reg_write, 1'b0);
    chk("x31.wb_data", wb_data, 64'h77);

    // Load then store back-to-back, each acked on its second request cycle
    @(negedge clk); set_op(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 64'h200, 64'd0);
    @(negedge clk); set_op(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 64'h300, 64'hAB); #1;
    chk("b2b.stall1", stall, 1'b1); chk("b2b.req1", dmem_req, 1'b1);
    @(negedge clk); dmem_ack = 1'b1; dmem_rdata = 64'h55; #1;
    chk("b2b.stall2", stall, 1'b0); chk("b2b.req2", dmem_req, 1'b1);
    @(negedge clk); idle_op(); dmem_ack = 1'b0; dmem_rdata = 64'd0; #1;
    chk("b2b.stall3", stall, 1'b1); chk("b2b.req3", dmem_req, 1'b1);
    chk("b2b.addr3", dmem_addr, 64'h300); chk("b2b.we3", dmem_we, 1'b1);
    chk("b2b.ld_wb_valid", wb_valid, 1'b1); chk("b2b.ld_wb_data", wb_data, 64'h55);
    chk("b2b.ld_wb_rd", wb_rd, 5'd9);
    @(negedge clk); dmem_ack = 1'b1; #1;
    chk("b2b.stall4", stall, 1'b0); chk("b2b.bubble", wb_valid, 1'b0);
    @(negedge clk); dmem_ack = 1'b0; #1;
    chk("b2b.req_off", dmem_req, 1'b0); chk("b2b.st_wb_valid", wb_valid, 1'b1);
    chk("b2b.st_wb_rw", wb_reg_write, 1'b0);

    // Read and write both set: behaves as a store
    @(negedge clk); set_op(1'b1, 1'b1, 1'b1, 1'b1, 5'd6, 64'h80, 64'hCC);
    @(negedge clk); idle_op(); dmem_ack = 1'b1; dmem_rdata = 64'hEE; #1;
    chk("rw.we", dmem_we, 1'b1); chk("rw.wdata", dmem_wdata, 64'hCC);
    @(negedge clk); dmem_ack = 1'b0; dmem_rdata = 64'd0; #1;
    chk("rw.wb_valid", wb_valid, 1'b1); chk("rw.wb_reg_write", wb_reg_write, 1'b0);
    chk("rw.wb_data", wb_data, 64'h80);

    // Reset during an outstanding access, followed by a late ack
    @(negedge clk); set_op(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 64'h500, 64'd0);
    @(negedge clk); idle_op(); #1;
    chk("ra.req", dmem_req, 1'b1);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1; dmem_ack = 1'b1; dmem_rdata = 64'h77; #1;
    chk("ra.req_off", dmem_req, 1'b0); chk("ra.stall", stall, 1'b0);
    @(negedge clk); dmem_ack = 1'b0; dmem_rdata = 64'd0; #1;
    chk("ra.wb_valid", wb_valid, 1'b0); chk("ra.wb_reg_write", wb_reg_write, 1'b0);

`ifdef MEM_STAGE_TIMEOUT_EN
    // No ack: request held for TO cycles then aborted
    @(negedge clk); set_op(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 64'h600, 64'd0);
    @(negedge clk); idle_op(); #1;
    chk("to.req1", dmem_req, 1'b1); chk("to.stall1", stall, 1'b1);
    @(negedge clk); #1; chk("to.req2", dmem_req, 1'b1); chk("to.stall2", stall, 1'b1);
    @(negedge clk); #1; chk("to.req3", dmem_req, 1'b1); chk("to.stall3", stall, 1'b1);
    @(negedge clk); #1;
    chk("to.req4", dmem_req, 1'b1); chk("to.stall4", stall, 1'b0); chk("to.err4", mem_error, 1'b0);
    @(negedge clk); #1;
    chk("to.req_off", dmem_req, 1'b0); chk("to.err", mem_error, 1'b1); chk("to.no_wb", wb_valid, 1'b0);
    repeat (3) @(negedge clk);
    #1; chk("to.sticky", mem_error, 1'b1);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1; #1;
    chk("to.err_clr", mem_error, 1'b0);

    // Ack on the final allowed cycle completes normally
    @(negedge clk); set_op(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 64'h610, 64'd0);
    @(negedge clk); idle_op();
    repeat (2) @(negedge clk);
    @(negedge clk); dmem_ack = 1'b1; dmem_rdata = 64'hFACE; #1;
    chk("tok.stall4", stall, 1'b0);
    @(negedge clk); dmem_ack = 1'b0; dmem_rdata = 64'd0; #1;
    chk("tok.wb_valid", wb_valid, 1'b1); chk("tok.wb_data", wb_data, 64'hFACE);
    chk("tok.err", mem_error, 1'b0);
`endif

    repeat (2) @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage LEGv8 pipeline, directly downstream of the execute stage. Holds the EX/MEM pipeline register. Drives a multi-cycle data-memory request/acknowledge interface for LDUR/STUR and stalls the upstream pipeline while an access is outstanding. Produces the MEM/WB register contents consumed by register-file writeback, and an ALU-result forwarding path back to execute.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles an access waits for acknowledge (used only under the configuration macro; legal range 2..255).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- ex_valid  input  1  execute stage presents a valid instruction this cycle
- ex_result  input  64  ALU/shifter result; memory address for loads/stores
- ex_store_data  input  64  store data (Db)
- ex_rd  input  5  destination register
- ex_mem_read  input  1  load (MemToReg)
- ex_mem_write  input  1  store
- ex_reg_write  input  1  instruction writes Rd
- stall  output  1  upstream must hold its instruction; inputs are ignored while high
- dmem_req  output  1  memory access request
- dmem_we  output  1  1 = write, 0 = read
- dmem_addr  output  64  access address
- dmem_wdata  output  64  write data
- dmem_rdata  input  64  read data, valid with dmem_ack
- dmem_ack  input  1  access complete
- wb_valid  output  1  MEM/WB register holds a retired instruction
- wb_data  output  64  writeback value (load data or ALU result)
- wb_rd  output  5  writeback register
- wb_reg_write  output  1  writeback enable
- fwd_en  output  1  EX/MEM holds a forwardable ALU result
- fwd_rd  output  5  forwarded register number
- fwd_data  output  64  forwarded value
- mem_error  output  1  sticky access-timeout flag

## Operation
- EX/MEM register (valid, result, store_data, rd, mem_read, mem_write, reg_write) loads from ex_* on every edge where stall=0; loads valid=0 when ex_valid=0.
- ex_mem_read and ex_mem_write both high: treated as store.
- FSM states: IDLE (EX/MEM empty or holds a non-memory op), ACCESS (EX/MEM holds a load/store awaiting ack). IDLE -> ACCESS when a valid memory op is captured; ACCESS -> IDLE on dmem_ack (or timeout); ACCESS -> ACCESS directly if a new memory op is captured on the ack edge.
- In ACCESS: dmem_req=1; dmem_addr, dmem_we, dmem_wdata driven from EX/MEM and held stable until ack. dmem_req=0 in IDLE. dmem_ack ignored in IDLE.
- stall = (state==ACCESS) & ~dmem_ack (combinational from ack).
- MEM/WB register loads when stall=0: wb_valid=EX/MEM valid; wb_data = dmem_rdata for a load, else EX/MEM result; wb_rd = rd; wb_reg_write = valid & reg_write & ~mem_write & (rd != 31).
- While stall=1: MEM/WB loads a bubble (wb_valid=0, wb_reg_write=0); wb_data/wb_rd hold.
- Store retires as wb_valid=1, wb_reg_write=0.
- Forwarding: fwd_en = EX/MEM valid & reg_write & ~mem_read & ~mem_write & (rd != 31); fwd_rd/fwd_data = EX/MEM rd/result. Loads are never forwarded from this stage.

## Timing
- Reset (reset=0 at an edge): EX/MEM and MEM/WB invalid, state IDLE; stall, dmem_req, dmem_we, wb_valid, wb_reg_write, fwd_en, mem_error = 0; all data/address/rd outputs = 0.
- Non-memory op presented cycle N: fwd_en in N+1; wb_valid in N+2.
- Memory op presented cycle N: dmem_req high from N+1; ack in cycle N+k (k≥1) -> stall low in N+k, wb_valid with load data in N+k+1. Zero-wait ack (k=1) adds no stall cycles.
- Reset during ACCESS: dmem_req low the cycle after the reset edge; a late ack is ignored; no writeback produced.
- Back-to-back memory ops: no idle cycle between ack and the next request.

## Configuration
- MEM_STAGE_TIMEOUT_EN defined: 8-bit counter clears on ACCESS entry, increments each ACCESS cycle without ack. Counter reaching TIMEOUT-1 with no ack: the access is aborted on that edge (state IDLE, stall low that cycle, MEM/WB gets a bubble for the op), and mem_error is set and held until reset. An ack in the same cycle wins: normal completion, no error.
- Undefined: no counter; ACCESS waits indefinitely; mem_error is constant 0.

## Test plan
- Reset: hold reset=0 two cycles with ex_valid=1 -> all outputs 0; release, ADD rd=3 result 0x5 -> fwd_en=1/fwd_rd=3 next cycle, wb_valid=1 wb_data=0x5 wb_reg_write=1 the cycle after.
- Load, ack after 3 cycles of req, rdata 0xDEADBEEF, rd=7 -> stall high exactly 2 cycles, dmem_we=0, addr stable, wb_data=0xDEADBEEF wb_rd=7 one cycle after ack, fwd_en=0 throughout.
- Store addr 0x40 data 0x1234, ack at k=1 -> dmem_we=1, wdata 0x1234, no stall, wb_valid=1 wb_reg_write=0.
- Rd=31 ALU op -> fwd_en=0, wb_reg_write=0, wb_valid=1.
- Load then store back-to-back, each acked at k=2 -> req never drops between accesses; stall pattern 1,0,1,0.
- With MEM_STAGE_TIMEOUT_EN, TIMEOUT=4, no ack -> req high 4 cycles, then mem_error=1 sticky, stall released, no writeback; repeat with ack on 4th cycle -> normal completion, mem_error=0.
